// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared 4:1 bit mux: grants one source
// at a time, drives the mux select, and registers the selected bit with a valid flag.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [3:0] REQ,
  input  logic [3:0] LAST,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  output logic       CTRL1,
  output logic       CTRL2,
  output logic [3:0] GNT,
  output logic       BUSY,
  output logic       OUT,
  output logic       OUT_VALID
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t     r_state;
  logic [1:0] r_ptr;
  logic [1:0] r_sel;
  logic [3:0] r_gnt;
  logic [7:0] r_hold;
  logic       r_out;
  logic       r_valid;

  logic [3:0] w_data;
  logic [1:0] w_scan_base;
  logic       w_win_found;
  logic [1:0] w_win_idx;
  logic       w_req_g;
  logic       w_last_g;
  logic       w_timeout;
  logic       w_release;

  assign w_data   = {D, C, B, A};
  assign w_req_g  = REQ[r_sel];
  assign w_last_g = LAST[r_sel];

  // While granted, arbitration only matters on release, when the pointer moves past g.
  assign w_scan_base = (r_state == ST_GRANT) ? (r_sel + 2'd1) : r_ptr;

  // Scan downward so the index closest to the base is the last (winning) assignment.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = w_scan_base;
    for (int k = 3; k >= 0; k--) begin
      if (REQ[w_scan_base + 2'(k)]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_scan_base + 2'(k);
      end
    end
  end

  assign w_timeout = (({1'b0, r_hold} + 9'd1) == 9'(MAX_HOLD));
  assign w_release = !w_req_g || w_last_g || w_timeout;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
      r_ptr   <= 2'd0;
      r_sel   <= 2'd0;
      r_gnt   <= 4'b0000;
      r_hold  <= 8'd0;
      r_out   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_valid <= 1'b0;
          if (w_win_found) begin
            r_state <= ST_GRANT;
            r_sel   <= w_win_idx;
            r_gnt   <= 4'b0001 << w_win_idx;
            r_hold  <= 8'd0;
          end
        end
        ST_GRANT: begin
          r_valid <= w_req_g;
          if (w_req_g) begin
            r_out <= w_data[r_sel];
          end
          r_hold <= r_hold + 8'd1;
          if (w_release) begin
            r_ptr <= r_sel + 2'd1;
            if (w_win_found) begin
              r_sel  <= w_win_idx;
              r_gnt  <= 4'b0001 << w_win_idx;
              r_hold <= 8'd0;
            end else begin
              r_state <= ST_IDLE;
              r_gnt   <= 4'b0000;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= 4'b0000;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign CTRL1     = r_sel[1];
  assign CTRL2     = r_sel[0];
  assign GNT       = r_gnt;
  assign BUSY      = (r_state == ST_GRANT);
  assign OUT       = r_out;
  assign OUT_VALID = r_valid;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios with literal expectations plus
// a per-cycle comparison against a behavioural model of the arbitration rules.
module tb_mux4_rr_arbiter;

  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] last;
  logic       a_in, b_in, c_in, d_in;
  logic       ctrl1, ctrl2;
  logic [3:0] gnt;
  logic       busy;
  logic       out_bit;
  logic       out_valid;

  int checks   = 0;
  int failures = 0;

  mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .CLK(clk),
    .RESET_N(rst_n),
    .REQ(req),
    .LAST(last),
    .A(a_in),
    .B(b_in),
    .C(c_in),
    .D(d_in),
    .CTRL1(ctrl1),
    .CTRL2(ctrl2),
    .GNT(gnt),
    .BUSY(busy),
    .OUT(out_bit),
    .OUT_VALID(out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: granted owner (-1 = none), priority pointer, granted-cycle count.
  int   m_g     = -1;
  int   m_ptr   = 0;
  int   m_hold  = 0;
  int   m_sel   = 0;
  logic m_out   = 1'b0;
  logic m_valid = 1'b0;

  function automatic int pick(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_g = -1; m_ptr = 0; m_hold = 0; m_sel = 0; m_out = 1'b0; m_valid = 1'b0;
    end else if (m_g < 0) begin
      int w;
      m_valid = 1'b0;
      w = pick(req, m_ptr);
      if (w >= 0) begin
        m_g = w; m_sel = w; m_hold = 0;
      end
    end else begin
      int w;
      logic [3:0] dv;
      dv = {d_in, c_in, b_in, a_in};
      m_valid = req[m_g];
      if (req[m_g]) m_out = dv[m_sel];
      m_hold = m_hold + 1;
      if (!req[m_g] || last[m_g] || m_hold == MAX_HOLD) begin
        m_ptr = (m_g + 1) % 4;
        w = pick(req, m_ptr);
        if (w >= 0) begin
          m_g = w; m_sel = w; m_hold = 0;
        end else begin
          m_g = -1;
        end
      end
    end
  end

  // Per-cycle compare on the falling edge, away from any DUT update.
  always @(negedge clk) begin
    logic [3:0] exp_gnt;
    logic [1:0] exp_sel;
    exp_gnt = (m_g < 0) ? 4'b0000 : (4'b0001 << m_g);
    exp_sel = 2'(m_sel);
    checks++;
    if (gnt !== exp_gnt || {ctrl1, ctrl2} !== exp_sel || busy !== (m_g >= 0) ||
        out_bit !== m_out || out_valid !== m_valid) begin
      failures++;
      $display("FAIL model_cmp t=%0t: got gnt=%b sel=%b busy=%b out=%b vld=%b, expected gnt=%b sel=%b busy=%b out=%b vld=%b",
               $time, gnt, {ctrl1, ctrl2}, busy, out_bit, out_valid,
               exp_gnt, exp_sel, (m_g >= 0), m_out, m_valid);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req = 4'b0000; last = 4'b0000;
    a_in = 1'b0; b_in = 1'b0; c_in = 1'b0; d_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_sel", 32'({ctrl1, ctrl2}), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_valid", 32'(out_valid), 32'h0);
    rst_n = 1'b1;

    // Single requester D
    req = 4'b1000; d_in = 1'b1;
    tick();
    chk("single_gnt", 32'(gnt), 32'h8);
    chk("single_sel", 32'({ctrl1, ctrl2}), 32'h3);
    chk("single_busy", 32'(busy), 32'h1);
    tick();
    chk("single_out", 32'(out_bit), 32'h1);
    chk("single_valid", 32'(out_valid), 32'h1);
    req = 4'b0000;
    tick();
    chk("single_idle_gnt", 32'(gnt), 32'h0);
    chk("single_idle_busy", 32'(busy), 32'h0);

    // Round robin with LAST in every first cycle
    a_in = 1'b0; b_in = 1'b1; c_in = 1'b0; d_in = 1'b1;
    req = 4'b1111; last = 4'b1111;
    tick();
    chk("rr_gnt0", 32'(gnt), 32'h1);
    tick();
    chk("rr_gnt1", 32'(gnt), 32'h2);
    chk("rr_out0", 32'(out_bit), 32'h0);
    chk("rr_vld0", 32'(out_valid), 32'h1);
    tick();
    chk("rr_gnt2", 32'(gnt), 32'h4);
    chk("rr_out1", 32'(out_bit), 32'h1);
    tick();
    chk("rr_gnt3", 32'(gnt), 32'h8);
    chk("rr_out2", 32'(out_bit), 32'h0);
    tick();
    chk("rr_gnt4", 32'(gnt), 32'h1);
    chk("rr_out3", 32'(out_bit), 32'h1);
    chk("rr_busy", 32'(busy), 32'h1);
    req = 4'b0000; last = 4'b0000;
    tick();
    chk("rr_idle_gnt", 32'(gnt), 32'h0);

    // Hold timeout from a fresh pointer
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    req = 4'b0011;
    tick();
    for (int i = 0; i < MAX_HOLD; i++) begin
      chk($sformatf("hold_a_cyc%0d", i + 1), 32'(gnt), 32'h1);
      tick();
    end
    for (int i = 0; i < MAX_HOLD; i++) begin
      chk($sformatf("hold_b_cyc%0d", i + 1), 32'(gnt), 32'h2);
      tick();
    end
    chk("hold_a_again", 32'(gnt), 32'h1);

    // Request drop: A loses its request, C takes over
    req = 4'b0100;
    tick();
    chk("drop_gnt", 32'(gnt), 32'h4);
    chk("drop_sel", 32'({ctrl1, ctrl2}), 32'h2);
    chk("drop_valid", 32'(out_valid), 32'h0);

    // Pointer wrap D -> A, then A alone re-granted back-to-back
    req = 4'b1000;
    tick();
    chk("wrap_d_gnt", 32'(gnt), 32'h8);
    req = 4'b1001; last = 4'b1000;
    tick();
    chk("wrap_a_gnt", 32'(gnt), 32'h1);
    req = 4'b0001; last = 4'b0001;
    tick();
    chk("sole_gnt1", 32'(gnt), 32'h1);
    chk("sole_busy1", 32'(busy), 32'h1);
    tick();
    chk("sole_gnt2", 32'(gnt), 32'h1);
    chk("sole_busy2", 32'(busy), 32'h1);

    // Asynchronous reset in the middle of a grant to C
    req = 4'b0100; last = 4'b0000;
    tick();
    chk("mid_c_gnt", 32'(gnt), 32'h4);
    tick();
    chk("mid_c_valid", 32'(out_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_sel", 32'({ctrl1, ctrl2}), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    req = 4'b0000;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter and sequencer for the shared 4:1 bit multiplexer. Four requesters (A, B, C, D) compete for the mux. The block grants one requester at a time, drives the mux select pair CTRL1/CTRL2, and holds the grant until the requester signals end of transfer, drops its request, or exceeds a hold limit. It also registers the selected data bit with a valid flag for downstream logic.

Parameters:
MAX_HOLD, 8, maximum consecutive granted cycles per grant before forced rotation (legal range 1..255).

Ports:
CLK  input  1  system clock; all state updates on rising edge
RESET_N  input  1  asynchronous, active-low reset
REQ  input  4  request per source; bit0=A, bit1=B, bit2=C, bit3=D
LAST  input  4  end-of-transfer flag per source, same bit order; only meaningful while that source is granted
A  input  1  data, source 0
B  input  1  data, source 1
C  input  1  data, source 2
D  input  1  data, source 3
CTRL1  output  1  mux select MSB (registered)
CTRL2  output  1  mux select LSB (registered)
GNT  output  4  one-hot grant, same bit order (registered)
BUSY  output  1  high while a grant is active
OUT  output  1  registered selected data bit
OUT_VALID  output  1  OUT holds a bit sampled from a granted, requesting source

Behaviour:
- Select encoding: {CTRL1,CTRL2} 00=A, 01=B, 10=C, 11=D. GNT is always one-hot or zero and always consistent with the select pair while BUSY=1.
- Reset (RESET_N=0, asynchronous): state IDLE, GNT=0000, {CTRL1,CTRL2}=00, BUSY=0, OUT=0, OUT_VALID=0, pointer PTR=0, hold count=0. Reset applied mid-grant aborts the grant immediately, with no completion cycle.
- Internal state: IDLE, GRANT; 2-bit PTR (highest-priority index); hold counter 8 bits wide.
- Arbitration function: scan REQ starting at PTR and wrap modulo 4; the first set bit wins.
- IDLE: if REQ!=0, the next edge moves to GRANT, loads GNT and the select with the winner, and clears the hold count. If REQ==0, stay in IDLE; the select keeps its last value and GNT=0.
- GRANT (granted index g): each cycle the hold count increments. A release occurs on the edge where any of the following holds:
  - REQ[g]=0, or
  - REQ[g]=1 and LAST[g]=1, or
  - the hold count reaches MAX_HOLD (the g-th granted cycle count equals MAX_HOLD).
- On release, PTR <= (g+1) mod 4. Arbitration is evaluated in the same cycle with the new PTR against the current REQ:
  - If there is a winner, move directly to GRANT with that winner and no idle bubble. g itself may win again if it is the only requester.
  - Otherwise go to IDLE with GNT=0 and BUSY=0.
- Simultaneous events: LAST and timeout in the same cycle count as a single release. Requests arriving during a grant wait for the next release. LAST[x] with x!=g is ignored.
- BUSY = (state==GRANT), registered together with GNT.
- Data path: on every edge in GRANT with REQ[g]=1, OUT <= selected input (A/B/C/D per the current select) and OUT_VALID <= 1. On all other edges, OUT_VALID <= 0 and OUT holds its value. Latency: data presented in the first granted cycle appears on OUT one edge later.
- Timing: REQ to GNT latency is exactly 1 edge from IDLE.

Test Plan:
1. Reset mid-grant: grant C active, pulse RESET_N=0 between edges -> GNT=0000, CTRL1=0, CTRL2=0, BUSY=0, OUT_VALID=0 immediately, without waiting for a clock edge.
2. Single requester: REQ=1000, D=1, LAST=0 -> after 1 edge GNT=1000, {CTRL1,CTRL2}=11, BUSY=1; after 2nd edge OUT=1, OUT_VALID=1.
3. Round robin: REQ=1111 with LAST[g] pulsed in each grant's first cycle -> grant sequence A,B,C,D,A on consecutive edges, no idle cycle; A=0,B=1,C=0,D=1 gives OUT sequence 0,1,0,1.
4. Hold timeout: MAX_HOLD=8, REQ=0011, LAST=0 -> A granted exactly 8 cycles, then B granted 8 cycles, then A again.
5. Request drop: A granted, REQ changes 0001->0100 -> next edge GNT=0100, {CTRL1,CTRL2}=10; OUT_VALID=0 for the dropped cycle.
6. Pointer wrap and sole requester: D released via LAST with REQ=1001 -> A granted next. Then only A requesting with LAST pulsed -> A re-granted back-to-back, BUSY stays 1.
